// File: rtl/pipelined_cla_adder_if.sv
// Handshake/data bundle for pipelined_cla_adder.
// Defining CLA_OVERFLOW_EN adds the ovf result signal.
interface pipelined_cla_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
`ifdef CLA_OVERFLOW_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, sum, co, ovf
  );
  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, sum, co, ovf
  );
`else
  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, sum, co
  );
  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, sum, co
  );
`endif
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead group per stage,
// global stall on output backpressure. Optional signed overflow output under CLA_OVERFLOW_EN.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipelined_cla_adder_if.slave  bus
);
  localparam int unsigned STAGES = WIDTH / BLOCK;
  localparam int unsigned LAST   = STAGES - 1;

  // Flat sum-of-products lookahead within one group; returns {carry_out, sum}.
  function automatic logic [BLOCK:0] cla_group(
    input logic [BLOCK-1:0] ga,
    input logic [BLOCK-1:0] gb,
    input logic             cin
  );
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;
    logic             term;
    g    = ga & gb;
    p    = ga ^ gb;
    c    = '0;
    c[0] = cin;
    for (int unsigned j = 0; j < BLOCK; j++) begin
      term = cin;
      for (int unsigned m = 0; m <= j; m++) term = term & p[m];
      c[j+1] = term;
      for (int unsigned i = 0; i <= j; i++) begin
        term = g[i];
        for (int unsigned m = i + 1; m <= j; m++) term = term & p[m];
        c[j+1] = c[j+1] | term;
      end
    end
    return {c[BLOCK], p ^ c[BLOCK-1:0]};
  endfunction

  logic [STAGES-1:0] valid_d, valid_q;
  logic [STAGES-1:0] c_d, c_q;
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  bp_d  [STAGES];
  logic [WIDTH-1:0]  bp_q  [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  bp0;
  logic [BLOCK:0]    grp;
  logic              adv;
`ifdef CLA_OVERFLOW_EN
  logic              ovf_d, ovf_q;
`endif

  always_comb begin
    adv = !valid_q[LAST] || bus.out_ready;
    bp0 = bus.sub ? ~bus.b : bus.b;

    // Stage 0 takes operands straight from the input port.
    grp          = cla_group(bus.a[BLOCK-1:0], bp0[BLOCK-1:0], bus.sub ? 1'b1 : bus.ci);
    valid_d[0]   = bus.in_valid;
    a_d[0]       = bus.a;
    bp_d[0]      = bp0;
    sum_d[0]     = '0;
    sum_d[0][BLOCK-1:0] = grp[BLOCK-1:0];
    c_d[0]       = grp[BLOCK];

    for (int unsigned k = 1; k < STAGES; k++) begin
      grp        = cla_group(a_q[k-1][k*BLOCK +: BLOCK], bp_q[k-1][k*BLOCK +: BLOCK], c_q[k-1]);
      valid_d[k] = valid_q[k-1];
      a_d[k]     = a_q[k-1];
      bp_d[k]    = bp_q[k-1];
      sum_d[k]   = sum_q[k-1];
      sum_d[k][k*BLOCK +: BLOCK] = grp[BLOCK-1:0];
      c_d[k]     = grp[BLOCK];
    end

`ifdef CLA_OVERFLOW_EN
    // Carry into the MSB is recovered as p_msb ^ sum_msb, avoiding a second carry output.
    ovf_d = a_d[LAST][WIDTH-1] ^ bp_d[LAST][WIDTH-1] ^ sum_d[LAST][WIDTH-1] ^ c_d[LAST];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      c_q     <= '0;
      a_q     <= '{default: '0};
      bp_q    <= '{default: '0};
      sum_q   <= '{default: '0};
`ifdef CLA_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else if (adv) begin
      valid_q <= valid_d;
      c_q     <= c_d;
      a_q     <= a_d;
      bp_q    <= bp_d;
      sum_q   <= sum_d;
`ifdef CLA_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    bus.in_ready  = adv;
    bus.out_valid = valid_q[LAST];
    bus.sum       = sum_q[LAST];
    bus.co        = c_q[LAST];
`ifdef CLA_OVERFLOW_EN
    bus.ovf       = ovf_q;
`endif
  end
endmodule
